// File: rtl/zcash_fpga_rpl_arbiter.sv
// Round-robin merge of FPGA-to-host reply packets onto one host stream.
// Locks one source per packet, enforces the header length and repairs bad framing.
module zcash_fpga_rpl_arbiter #(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned DAT_BYTS = 8,
    parameter int unsigned MOD_BITS = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_SRC*DAT_BYTS*8-1:0]   i_rx_dat,
    input  logic [N_SRC-1:0]              i_rx_val,
    input  logic [N_SRC-1:0]              i_rx_sop,
    input  logic [N_SRC-1:0]              i_rx_eop,
    input  logic [N_SRC*MOD_BITS-1:0]     i_rx_mod,
    output logic [N_SRC-1:0]              o_rx_rdy,
    output logic [DAT_BYTS*8-1:0]         o_tx_dat,
    output logic                          o_tx_val,
    output logic                          o_tx_sop,
    output logic                          o_tx_eop,
    output logic [MOD_BITS-1:0]           o_tx_mod,
    input  logic                          i_tx_rdy,
    output logic                          o_len_err,
    output logic [15:0]                   o_err_cnt,
    output logic [N_SRC-1:0]              o_grant
);

    localparam int unsigned DAT_BITS = DAT_BYTS * 8;
    localparam int unsigned IW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FWD   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       lock_q, lock_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [31:0]         rem_q, rem_d;
    logic                tx_val_q, tx_val_d;
    logic [DAT_BITS-1:0] tx_dat_q, tx_dat_d;
    logic                tx_sop_q, tx_sop_d;
    logic                tx_eop_q, tx_eop_d;
    logic [MOD_BITS-1:0] tx_mod_q, tx_mod_d;
    logic                len_err_q;
    logic [15:0]         err_cnt_q;

    logic                out_free;
    logic                found;
    logic [IW-1:0]       pick, cand, sel;
    logic [DAT_BITS-1:0] sdat;
    logic                sval, ssop, seop;
    logic [MOD_BITS-1:0] smod;
    logic [N_SRC-1:0]    rdy;
    logic                take, is_hdr, err;
    logic [31:0]         cur;

    // Source lookup: in IDLE the round-robin candidate, otherwise the locked source.
    always_comb begin
        out_free = i_tx_rdy || !tx_val_q;
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = IW'((int'(ptr_q) + i) % N_SRC);
            if (!found && i_rx_val[cand] && i_rx_sop[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        sel  = (state_q == IDLE) ? pick : lock_q;
        sdat = i_rx_dat[int'(sel)*DAT_BITS +: DAT_BITS];
        sval = i_rx_val[sel];
        ssop = i_rx_sop[sel];
        seop = i_rx_eop[sel];
        smod = i_rx_mod[int'(sel)*MOD_BITS +: MOD_BITS];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        lock_d   = lock_q;
        grant_d  = grant_q;
        rem_d    = rem_q;
        tx_val_d = tx_val_q;
        tx_dat_d = tx_dat_q;
        tx_sop_d = tx_sop_q;
        tx_eop_d = tx_eop_q;
        tx_mod_d = tx_mod_q;
        rdy      = '0;
        take     = 1'b0;
        is_hdr   = 1'b0;
        err      = 1'b0;
        cur      = rem_q;
        if (out_free) begin
            tx_val_d = 1'b0;
            tx_sop_d = 1'b0;
            tx_eop_d = 1'b0;
            tx_mod_d = '0;
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    if (out_free) begin
                        rdy[pick] = 1'b1;
                        take      = 1'b1;
                        is_hdr    = 1'b1;
                        cur       = (sdat[31:0] < 32'd8) ? 32'd8 : sdat[31:0];
                        ptr_d     = (pick == IW'(N_SRC - 1)) ? '0 : pick + 1'b1;
                        lock_d    = pick;
                        grant_d   = '0;
                        grant_d[pick] = 1'b1;
                        state_d   = FWD;
                    end
                end else begin
                    // Stray non-sop beats are swallowed only when nobody is starting a packet.
                    for (int i = 0; i < N_SRC; i++) begin
                        if (i_rx_val[i] && !i_rx_sop[i]) begin
                            rdy[i] = 1'b1;
                            err    = 1'b1;
                        end
                    end
                end
            end
            FWD: begin
                if (out_free) begin
                    rdy[lock_q] = 1'b1;
                    if (sval) begin
                        take = 1'b1;
                        err  = ssop;
                    end
                end
            end
            DRAIN: begin
                rdy[lock_q] = 1'b1;
                if (sval && seop) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            tx_val_d = 1'b1;
            tx_dat_d = sdat;
            tx_sop_d = is_hdr;
            tx_eop_d = 1'b0;
            tx_mod_d = '0;
            rem_d    = (cur > 32'd8) ? cur - 32'd8 : '0;
            if (seop) begin
                tx_eop_d = 1'b1;
                tx_mod_d = smod;
                err      = err | (cur > 32'd8);
                state_d  = IDLE;
                grant_d  = '0;
            end else if (cur <= 32'd8) begin
                // Length exhausted without eop: close the packet here, drop the rest.
                tx_eop_d = 1'b1;
                tx_mod_d = cur[MOD_BITS-1:0];
                err      = 1'b1;
                state_d  = DRAIN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lock_q    <= '0;
            grant_q   <= '0;
            rem_q     <= '0;
            tx_val_q  <= 1'b0;
            tx_dat_q  <= '0;
            tx_sop_q  <= 1'b0;
            tx_eop_q  <= 1'b0;
            tx_mod_q  <= '0;
            len_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            grant_q   <= grant_d;
            rem_q     <= rem_d;
            tx_val_q  <= tx_val_d;
            tx_dat_q  <= tx_dat_d;
            tx_sop_q  <= tx_sop_d;
            tx_eop_q  <= tx_eop_d;
            tx_mod_q  <= tx_mod_d;
            len_err_q <= err;
            if (err && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Ready is combinational, so hold it low while reset is asserted.
    assign o_rx_rdy  = rdy & {N_SRC{i_rst_n}};
    assign o_tx_dat  = tx_dat_q;
    assign o_tx_val  = tx_val_q;
    assign o_tx_sop  = tx_sop_q;
    assign o_tx_eop  = tx_eop_q;
    assign o_tx_mod  = tx_mod_q;
    assign o_len_err = len_err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_grant   = grant_q;

endmodule

// File: doc/zcash_fpga_rpl_arbiter.md
# zcash_fpga_rpl_arbiter

Round-robin arbiter that merges FPGA-to-host reply packets from several independent reply sources onto the single host reply stream. Sources include the control state machine (RESET_FPGA_RPL, FPGA_STATUS_RPL, FPGA_IGNORE_RPL), the equihash and secp256k1 verifiers, and the BLS12-381 interrupt path.

- Each packet starts with a 64-bit `header_t` beat (`cmd` in [63:32], `len` in bytes in [31:0]).
- The arbiter locks onto one source per packet and enforces the header length.
- Malformed packets are repaired so the host stream always stays framed.

## Interface

Parameters:
- N_SRC, 4, number of reply sources (2..8); source 0 has priority on the first arbitration after reset.
- DAT_BYTS, 8, bytes per beat (fixed at 8; the header occupies exactly one beat).
- MOD_BITS, 3, width of the byte-valid field, log2(DAT_BYTS).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rx_dat  in  N_SRC*64  per-source data, source k in [k*64 +: 64].
- i_rx_val  in  N_SRC  per-source valid.
- i_rx_sop  in  N_SRC  per-source start of packet.
- i_rx_eop  in  N_SRC  per-source end of packet.
- i_rx_mod  in  N_SRC*3  per-source valid bytes on the eop beat; 0 means all 8.
- o_rx_rdy  out  N_SRC  per-source ready.
- o_tx_dat  out  64  merged data.
- o_tx_val  out  1  merged valid.
- o_tx_sop  out  1  merged start of packet.
- o_tx_eop  out  1  merged end of packet.
- o_tx_mod  out  3  merged valid bytes on the eop beat.
- i_tx_rdy  in  1  host-side ready.
- o_len_err  out  1  one-cycle pulse on a length/framing violation.
- o_err_cnt  out  16  saturating count of violations.
- o_grant  out  N_SRC  one-hot source currently locked; 0 when idle.

## Operation

- Transfer rule: a beat moves on a port when val && rdy.
- States:
  - IDLE: no source locked.
  - FWD: forwarding the locked source.
  - DRAIN: discarding the remainder of an overlong source packet.
- IDLE:
  - Among sources with val && sop, pick the first at or after the round-robin pointer.
  - Lock it (o_grant), load the byte counter with header `len`, forward the header beat, go to FWD.
  - The pointer advances to the granted index + 1 (mod N_SRC) at grant time.
  - A source with val && !sop while idle is stray: o_rx_rdy high for it, beat dropped, o_len_err pulses.
  - Stray beats are accepted only when no sop candidate exists that cycle.
- Byte counter:
  - 32-bit, counts bytes remaining including the current beat.
  - Decrements by 8 per forwarded beat (header included), saturating at 0.
  - The header beat counts toward `len`. `len` < 8 is treated as 8.
- FWD, normal end: source eop when remaining ≤ 8.
  - Output eop with the source's mod.
  - Go to IDLE.
- FWD, early eop: source eop when remaining > 8.
  - Output eop unchanged.
  - o_len_err pulses.
  - Go to IDLE.
- FWD, overlong: remaining ≤ 8 but source not eop.
  - Output forced eop with o_tx_mod = remaining[2:0].
  - o_len_err pulses.
  - Go to DRAIN.
- FWD, sop mid-packet: counts as an early eop on the previous beat? No: the beat is forwarded with sop cleared and o_len_err pulses.
- DRAIN:
  - o_rx_rdy high for the locked source only; beats are discarded, nothing is output.
  - On its eop, go to IDLE.
- o_rx_rdy is 0 for all non-locked sources in FWD/DRAIN.
- o_err_cnt increments on each o_len_err pulse and saturates at 16'hFFFF.

## Timing

- Output is a single register stage; latency is 1 cycle from source accept to o_tx_val.
- Locked-source ready = i_tx_rdy || !o_tx_val, which sustains full throughput of 1 beat/cycle.
- o_tx_* hold stable while o_tx_val && !i_tx_rdy.
- Arbitration takes 0 bubble cycles: a new header may be accepted in the cycle after the previous eop is accepted.
- Reset values:
  - o_tx_val, o_tx_sop, o_tx_eop, o_len_err: 0.
  - o_tx_dat: 0; o_tx_mod: 0.
  - o_rx_rdy: 0; o_grant: 0; o_err_cnt: 0.
  - State IDLE; round-robin pointer 0.
- Reset mid-packet: the partial packet is abandoned. Sources must restart with sop.

## Test plan

- Single source 1 sends FPGA_STATUS_RPL, len 0x29 (6 beats) -> 6 output beats; sop on the first, eop on the sixth with mod 1; o_len_err never pulses.
- Sources 0, 1, 2 each hold 2-beat packets simultaneously after reset -> packets output in order 0, 1, 2 with no idle cycles; o_grant sequence 001, 010, 100.
- Source 3 sends header len 16 but 4 beats -> output 2 beats with eop forced on beat 2, mod 0; beats 3-4 drained; o_len_err pulses once; o_err_cnt = 1.
- Source 0 sends header len 32 but eop on beat 2 -> output 2 beats ending in eop; o_len_err pulses; arbiter returns to IDLE.
- Random i_tx_rdy throttling (50%) with 3 sources streaming BLS12_381_INTERRUPT_RPL -> byte-exact output with no lost or duplicated beats; o_tx_* stable while stalled.
- Assert i_rst_n low during beat 3 of a 5-beat packet -> all outputs 0 immediately; the next packet after release is granted to source 0 first.
